// File: rtl/brick_map_gen.sv
// brick_map_gen: scans the tile grid row-major at one tile per clock and writes walls, spawn clearings and random bricks into the map RAM
module brick_map_gen #(
    parameter int unsigned MAP_W        = 15,
    parameter int unsigned MAP_H        = 13,
    parameter int unsigned BRICK_THRESH = 10,
    parameter int unsigned MAX_BRICKS   = 255,
    localparam int unsigned ADDR_W      = $clog2(MAP_W*MAP_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start_i,
    input  logic [3:0]        randhex_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        wr_data_o,
    output logic [7:0]        brick_count_o
);
    localparam int unsigned XW = $clog2(MAP_W);
    localparam int unsigned YW = $clog2(MAP_H);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        wr_data_q, wr_data_d;
    logic              x_last, last, wall, spawn, brick;

    // Classify the tile at the current scan position; randhex is used in the same cycle it arrives
    always_comb begin
        x_last = x_q == XW'(MAP_W-1);
        last   = x_last && y_q == YW'(MAP_H-1);
        wall   = x_q == '0 || y_q == '0 || x_last || y_q == YW'(MAP_H-1) || (!x_q[0] && !y_q[0]);
        spawn  = (x_q == XW'(1) && y_q == YW'(1)) || (x_q == XW'(2) && y_q == YW'(1)) ||
                 (x_q == XW'(1) && y_q == YW'(2)) ||
                 (x_q == XW'(MAP_W-2) && y_q == YW'(MAP_H-2)) ||
                 (x_q == XW'(MAP_W-3) && y_q == YW'(MAP_H-2)) ||
                 (x_q == XW'(MAP_W-2) && y_q == YW'(MAP_H-3));
        brick  = !wall && !spawn && {1'b0, randhex_i} < 5'(BRICK_THRESH) && cnt_q < 8'(MAX_BRICKS);
    end

    // State and all registered outputs; reset wins over everything, including mid-scan
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state: start only counts in IDLE, scan ends on the last tile, FIN lasts one cycle
    always_comb begin
        state_d = state_q == IDLE ? (start_i ? SCAN : IDLE) :
                  state_q == SCAN ? (last ? FIN : SCAN) : IDLE;
    end

    // Next outputs and scan counters; done is registered out of FIN so it follows the last write
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == IDLE && start_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            cnt_d  = '0;
        end
        if (state_q == SCAN) begin
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = wall ? 2'd1 : brick ? 2'd2 : 2'd0;
            cnt_d     = cnt_q + {7'b0, brick};
            x_d       = x_last ? '0 : x_q + XW'(1);
            y_d       = x_last ? y_q + YW'(1) : y_q;
            addr_d    = addr_q + ADDR_W'(1);
        end
        if (state_q == FIN)
            done_d = 1'b1;
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign brick_count_o = cnt_q;
endmodule

// File: tb/tb_brick_map_gen.sv
// tb_brick_map_gen: randomized bench comparing two generator instances (default cap and cap 20) against a tile-index model
module tb_brick_map_gen;
    localparam int W = 15, H = 13, N = W*H, TH = 10;
    localparam int CAP[2] = '{255, 20};

    logic       Clk = 0, Reset = 1, start_i = 0;
    logic [3:0] randhex_i = 0;
    logic       busy[2], done[2], wr_en[2];
    logic [7:0] wr_addr[2], cnt[2];
    logic [1:0] wr_data[2];

    brick_map_gen #(.MAP_W(W), .MAP_H(H), .BRICK_THRESH(TH), .MAX_BRICKS(255)) dut0 (
        .Clk(Clk), .Reset(Reset), .start_i(start_i), .randhex_i(randhex_i),
        .busy_o(busy[0]), .done_o(done[0]), .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]),
        .wr_data_o(wr_data[0]), .brick_count_o(cnt[0]));
    brick_map_gen #(.MAP_W(W), .MAP_H(H), .BRICK_THRESH(TH), .MAX_BRICKS(20)) dut1 (
        .Clk(Clk), .Reset(Reset), .start_i(start_i), .randhex_i(randhex_i),
        .busy_o(busy[1]), .done_o(done[1]), .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]),
        .wr_data_o(wr_data[1]), .brick_count_o(cnt[1]));

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tile code straight from the map rules, using the tile's linear index
    function automatic int tile_code(input int a, input int rh, input int c, input int cap);
        int x, y;
        x = a % W;
        y = a / W;
        if (x == 0 || y == 0 || x == W-1 || y == H-1 || (x % 2 == 0 && y % 2 == 0)) return 1;
        if ((x == 1 && y == 1) || (x == 2 && y == 1) || (x == 1 && y == 2) ||
            (x == W-2 && y == H-2) || (x == W-3 && y == H-2) || (x == W-2 && y == H-3)) return 0;
        return (rh < TH && c < cap) ? 2 : 0;
    endfunction

    // Model: phase -1 idle, 0..N-1 next tile to write, N means the done cycle comes next
    int ph[2] = '{-1, -1};
    int e_en[2], e_busy[2], e_done[2], e_addr[2], e_data[2], e_cnt[2];
    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            if (Reset) begin
                ph[d] = -1; e_en[d] = 0; e_busy[d] = 0; e_done[d] = 0;
                e_addr[d] = 0; e_data[d] = 0; e_cnt[d] = 0;
            end else if (ph[d] < 0) begin
                e_en[d] = 0; e_busy[d] = 0; e_done[d] = 0;
                if (start_i) begin
                    ph[d] = 0;
                    e_cnt[d] = 0;
                end
            end else if (ph[d] < N) begin
                e_en[d] = 1; e_busy[d] = 1; e_done[d] = 0;
                e_addr[d] = ph[d];
                e_data[d] = tile_code(ph[d], int'(randhex_i), e_cnt[d], CAP[d]);
                if (e_data[d] == 2) e_cnt[d]++;
                ph[d]++;
            end else begin
                e_en[d] = 0; e_busy[d] = 0; e_done[d] = 1;
                ph[d] = -1;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d wr_en", d), int'(wr_en[d]), e_en[d]);
                chk($sformatf("dut%0d busy", d), int'(busy[d]), e_busy[d]);
                chk($sformatf("dut%0d done", d), int'(done[d]), e_done[d]);
                chk($sformatf("dut%0d wr_addr", d), int'(wr_addr[d]), e_addr[d]);
                chk($sformatf("dut%0d wr_data", d), int'(wr_data[d]), e_data[d]);
                chk($sformatf("dut%0d brick_count", d), int'(cnt[d]), e_cnt[d]);
            end
        end
    end

    logic [15:0] lfsr = 16'hACE1;
    int n0[4], n1[4], done_c, saw_done, post_rst;

    task automatic next_rh(input int mode, output logic [3:0] v);
        if (mode == 0) v = 4'd0;
        else if (mode == 1) v = 4'd15;
        else if (mode == 2) v = 4'($urandom_range(0, 15));
        else begin
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            v = lfsr[3:0];
        end
    endtask

    // One map generation; restart_at/reset_at > 0 inject start or Reset when that address is seen
    task automatic run(input int mode, input int restart_at, input int reset_at);
        logic [3:0] v;
        int rst_c;
        n0 = '{default: 0};
        n1 = '{default: 0};
        done_c = -1; saw_done = 0; post_rst = -1; rst_c = -1;
        next_rh(mode, v);
        randhex_i = v;
        start_i = 1;
        for (int c = 0; c < 260; c++) begin
            @(negedge Clk);
            start_i = 0;
            Reset = 0;
            if (rst_c >= 0 && c == rst_c + 1) post_rst = int'(wr_en[0] | busy[0] | done[0]);
            if (wr_en[0]) n0[wr_data[0]]++;
            if (wr_en[1]) n1[wr_data[1]]++;
            if (done[0]) begin
                done_c = c;
                saw_done++;
            end
            if (restart_at > 0 && wr_en[0] && int'(wr_addr[0]) == restart_at) start_i = 1;
            if (reset_at > 0 && wr_en[0] && int'(wr_addr[0]) == reset_at) begin
                Reset = 1;
                rst_c = c;
            end
            next_rh(mode, v);
            randhex_i = v;
            if (done_c >= 0 || (rst_c >= 0 && c > rst_c + 30)) break;
        end
        start_i = 0;
        Reset = 0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        Reset = 1;
        start_i = 1;
        @(posedge Clk);
        chk_en = 1;
        repeat (3) @(negedge Clk);
        chk("reset wr_en", int'(wr_en[0] | wr_en[1]), 0);
        chk("reset busy/done", int'(busy[0] | done[0]), 0);
        chk("reset brick_count", int'(cnt[0]), 0);
        Reset = 0;
        start_i = 0;
        repeat (2) @(negedge Clk);

        run(0, 0, 0);
        chk("all-brick walls", n0[1], 82);
        chk("all-brick bricks", n0[2], 107);
        chk("all-brick empties", n0[0], 6);
        chk("all-brick count", int'(cnt[0]), 107);
        chk("cap20 bricks written", n1[2], 20);
        chk("cap20 count", int'(cnt[1]), 20);
        chk("done cycle", done_c, N + 1);
        chk("done pulses", saw_done, 1);

        run(1, 0, 0);
        chk("no-brick bricks", n0[2], 0);
        chk("no-brick empties", n0[0], 113);
        chk("no-brick count", int'(cnt[0]), 0);

        run(0, 40, 0);
        chk("restart ignored done cycle", done_c, N + 1);
        chk("restart ignored writes", n0[0] + n0[1] + n0[2], N);

        run(2, 0, 50);
        chk("mid-scan reset outputs", post_rst, 0);
        chk("mid-scan reset no done", saw_done, 0);

        lfsr = 16'hACE1;
        run(3, 0, 0);
        chk("lfsr walls", n0[1], 82);
        chk("lfsr count vs writes", int'(cnt[0]), n0[2]);
        chk("lfsr done cycle", done_c, N + 1);

        for (int r = 0; r < 3; r++) begin
            run(2, 0, 0);
            chk("random count vs writes", int'(cnt[0]), n0[2]);
            chk("random cap20 count vs writes", int'(cnt[1]), n1[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
